// File: rtl/sccb_write_arbiter.sv
// Two-requester arbiter in front of the shared SCCB write master (slave 0x21).
// Build option: define SCCB_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module sccb_write_arbiter #(
  parameter int GAP_CLKS     = 125,
  parameter int START_WIN    = 4,
  parameter int TIMEOUT_CLKS = 250000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0,
  input  logic [7:0] i_addr0,
  input  logic [7:0] i_data0,
  output logic       o_ack0,
  output logic       o_done0,
  input  logic       i_req1,
  input  logic [7:0] i_addr1,
  input  logic [7:0] i_data1,
  output logic       o_ack1,
  output logic       o_done1,
  output logic       o_err,
  output logic       o_owner,
  output logic       o_busy,
  output logic       o_wr,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_wdata,
  input  logic       i_m_busy
);

  localparam int GAP_W   = (GAP_CLKS > 0)     ? $clog2(GAP_CLKS + 1)     : 1;
  localparam int START_W = (START_WIN > 0)    ? $clog2(START_WIN + 1)    : 1;
  localparam int TMO_W   = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;

  localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(GAP_CLKS);
  localparam logic [START_W-1:0] START_LOAD = START_W'(START_WIN);
  // The START cycle that first sees busy high already counts as one busy cycle.
  localparam logic [TMO_W-1:0]   TMO_LOAD   = (TIMEOUT_CLKS > 0) ? TMO_W'(TIMEOUT_CLKS - 1) : '0;

  localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);
  localparam logic [START_W-1:0] START_ONE = START_W'(1);
  localparam logic [TMO_W-1:0]   TMO_ONE   = TMO_W'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, START, RUN, GAP} state_t;

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [START_W-1:0] start_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               pick1;

`ifdef SCCB_ARB_RR_EN
  logic last1;
  // On a tie the requester that was not served last wins.
  assign pick1 = i_req1 & (~i_req0 | ~last1);
`else
  assign pick1 = i_req1 & ~i_req0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      start_cnt  <= '0;
      tmo_cnt    <= '0;
      o_ack0     <= 1'b0;
      o_ack1     <= 1'b0;
      o_done0    <= 1'b0;
      o_done1    <= 1'b0;
      o_err      <= 1'b0;
      o_owner    <= 1'b0;
      o_busy     <= 1'b0;
      o_wr       <= 1'b0;
      o_reg_addr <= '0;
      o_wdata    <= '0;
`ifdef SCCB_ARB_RR_EN
      last1      <= 1'b1;
`endif
    end else begin
      // NOTE: pulse outputs default low every cycle; each branch only raises what it needs.
      o_ack0  <= 1'b0;
      o_ack1  <= 1'b0;
      o_wr    <= 1'b0;
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        IDLE: begin
          if ((i_req0 || i_req1) && !i_m_busy) begin
            o_owner    <= pick1;
            o_ack0     <= ~pick1;
            o_ack1     <= pick1;
            o_reg_addr <= pick1 ? i_addr1 : i_addr0;
            o_wdata    <= pick1 ? i_data1 : i_data0;
            o_busy     <= 1'b1;
            state      <= ISSUE;
`ifdef SCCB_ARB_RR_EN
            last1      <= pick1;
`endif
          end
        end
        ISSUE: begin
          o_wr      <= 1'b1;
          start_cnt <= START_LOAD;
          state     <= START;
        end
        START: begin
          if (i_m_busy) begin
            tmo_cnt <= TMO_LOAD;
            state   <= RUN;
          end else if (start_cnt <= START_ONE) begin
            o_done0 <= ~o_owner;
            o_done1 <= o_owner;
            o_err   <= 1'b1;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else begin
            start_cnt <= start_cnt - START_ONE;
          end
        end
        RUN: begin
          // Busy still high when the window closes means the master stalled.
          if (!i_m_busy || tmo_cnt <= TMO_ONE) begin
            o_done0 <= ~o_owner;
            o_done1 <= o_owner;
            o_err   <= i_m_busy;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_ONE;
          end
        end
        GAP: begin
          if (gap_cnt <= GAP_ONE) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed bench for sccb_write_arbiter: cycle-accurate vector table plus reset and arbitration sequences.
module tb_sccb_write_arbiter;

  localparam int GAP = 6;
  localparam int SW  = 4;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, mb;
  logic [7:0] a0, d0, a1, d1;
  logic       ack0, ack1, done0, done1, err, owner, busy, wr;
  logic [7:0] reg_addr, wdata;
  logic [23:0] outs;

  int tests = 0;
  int fails = 0;

  always #4 clk = ~clk;

  sccb_write_arbiter #(.GAP_CLKS(GAP), .START_WIN(SW), .TIMEOUT_CLKS(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_addr0(a0), .i_data0(d0), .o_ack0(ack0), .o_done0(done0),
    .i_req1(req1), .i_addr1(a1), .i_data1(d1), .o_ack1(ack1), .o_done1(done1),
    .o_err(err), .o_owner(owner), .o_busy(busy), .o_wr(wr),
    .o_reg_addr(reg_addr), .o_wdata(wdata), .i_m_busy(mb)
  );

  assign outs = {ack0, ack1, wr, done0, done1, err, owner, busy, reg_addr, wdata};

  typedef struct {
    int          n;
    logic        r0;
    logic [7:0]  a0, d0;
    logic        r1;
    logic [7:0]  a1, d1;
    logic        mb;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] pk(logic k0, logic k1, logic w, logic n0, logic n1,
                                     logic e, logic o, logic b, logic [7:0] ra, logic [7:0] wd);
    return {k0, k1, w, n0, n1, e, o, b, ra, wd};
  endfunction

  function automatic vec_t mk(int n, logic r0, logic [7:0] x0, logic [7:0] y0,
                              logic r1, logic [7:0] x1, logic [7:0] y1, logic m, logic [23:0] e);
    vec_t v;
    v.n = n; v.r0 = r0; v.a0 = x0; v.d0 = y0;
    v.r1 = r1; v.a1 = x1; v.d1 = y1; v.mb = m; v.exp = e;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Outputs are sampled and inputs changed 1 ns after each rising edge.
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  k;
    int  seen;
    logic exp_who;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; mb = 1'b0;
    a0 = '0; d0 = '0; a1 = '0; d1 = '0;
    step(2);
    check("reset_state", 32'(outs), 32'h0);
    rst = 1'b0;

    // Contention: requester 0 wins, requester 1 follows after the gap and hits a start failure.
    tbl.push_back(mk(1,     1, 8'h34, 8'h01, 1, 8'h56, 8'h02, 0, pk(1,0,0,0,0,0,0,1,8'h34,8'h01)));
    tbl.push_back(mk(1,     0, 8'h34, 8'h01, 1, 8'h56, 8'h02, 0, pk(0,0,1,0,0,0,0,1,8'h34,8'h01)));
    tbl.push_back(mk(1,     0, 8'h34, 8'h01, 1, 8'h56, 8'h02, 1, pk(0,0,0,0,0,0,0,1,8'h34,8'h01)));
    tbl.push_back(mk(1,     0, 8'h34, 8'h01, 1, 8'h56, 8'h02, 0, pk(0,0,0,1,0,0,0,1,8'h34,8'h01)));
    tbl.push_back(mk(GAP-1, 0, 8'h34, 8'h01, 1, 8'h56, 8'h02, 0, pk(0,0,0,0,0,0,0,1,8'h34,8'h01)));
    tbl.push_back(mk(1,     0, 8'h34, 8'h01, 1, 8'h56, 8'h02, 0, pk(0,0,0,0,0,0,0,0,8'h34,8'h01)));
    tbl.push_back(mk(1,     0, 8'h34, 8'h01, 1, 8'h56, 8'h02, 0, pk(0,1,0,0,0,0,1,1,8'h56,8'h02)));
    tbl.push_back(mk(1,     0, 8'h34, 8'h01, 0, 8'h56, 8'h02, 0, pk(0,0,1,0,0,0,1,1,8'h56,8'h02)));
    tbl.push_back(mk(SW-1,  0, 8'h34, 8'h01, 0, 8'h56, 8'h02, 0, pk(0,0,0,0,0,0,1,1,8'h56,8'h02)));
    tbl.push_back(mk(1,     0, 8'h34, 8'h01, 0, 8'h56, 8'h02, 0, pk(0,0,0,0,1,1,1,1,8'h56,8'h02)));
    tbl.push_back(mk(GAP-1, 0, 8'h34, 8'h01, 0, 8'h56, 8'h02, 0, pk(0,0,0,0,0,0,1,1,8'h56,8'h02)));
    tbl.push_back(mk(1,     0, 8'h34, 8'h01, 0, 8'h56, 8'h02, 0, pk(0,0,0,0,0,0,1,0,8'h56,8'h02)));
    // Single write from requester 0; busy rises 2 cycles after o_wr and lasts 100 cycles.
    tbl.push_back(mk(1,     1, 8'h12, 8'h80, 0, 8'h56, 8'h02, 0, pk(1,0,0,0,0,0,0,1,8'h12,8'h80)));
    tbl.push_back(mk(1,     0, 8'h12, 8'h80, 0, 8'h56, 8'h02, 0, pk(0,0,1,0,0,0,0,1,8'h12,8'h80)));
    tbl.push_back(mk(2,     0, 8'h12, 8'h80, 0, 8'h56, 8'h02, 0, pk(0,0,0,0,0,0,0,1,8'h12,8'h80)));
    tbl.push_back(mk(1,     0, 8'h12, 8'h80, 0, 8'h56, 8'h02, 1, pk(0,0,0,0,0,0,0,1,8'h12,8'h80)));
    tbl.push_back(mk(99,    0, 8'h12, 8'h80, 0, 8'h56, 8'h02, 1, pk(0,0,0,0,0,0,0,1,8'h12,8'h80)));
    tbl.push_back(mk(1,     0, 8'h12, 8'h80, 0, 8'h56, 8'h02, 0, pk(0,0,0,1,0,0,0,1,8'h12,8'h80)));
    tbl.push_back(mk(1,     0, 8'h12, 8'h80, 0, 8'h56, 8'h02, 0, pk(0,0,0,0,0,0,0,1,8'h12,8'h80)));
    tbl.push_back(mk(GAP-2, 0, 8'h12, 8'h80, 0, 8'h56, 8'h02, 0, pk(0,0,0,0,0,0,0,1,8'h12,8'h80)));
    tbl.push_back(mk(1,     0, 8'h12, 8'h80, 0, 8'h56, 8'h02, 0, pk(0,0,0,0,0,0,0,0,8'h12,8'h80)));
    // Foreign busy blocks requester 1, then a stall that times out after TMO busy cycles.
    tbl.push_back(mk(3,     0, 8'h12, 8'h80, 1, 8'h9A, 8'hBC, 1, pk(0,0,0,0,0,0,0,0,8'h12,8'h80)));
    tbl.push_back(mk(1,     0, 8'h12, 8'h80, 1, 8'h9A, 8'hBC, 0, pk(0,1,0,0,0,0,1,1,8'h9A,8'hBC)));
    tbl.push_back(mk(1,     0, 8'h12, 8'h80, 0, 8'h9A, 8'hBC, 0, pk(0,0,1,0,0,0,1,1,8'h9A,8'hBC)));
    tbl.push_back(mk(TMO-1, 0, 8'h12, 8'h80, 0, 8'h9A, 8'hBC, 1, pk(0,0,0,0,0,0,1,1,8'h9A,8'hBC)));
    tbl.push_back(mk(1,     0, 8'h12, 8'h80, 0, 8'h9A, 8'hBC, 1, pk(0,0,0,0,1,1,1,1,8'h9A,8'hBC)));
    tbl.push_back(mk(GAP,   0, 8'h12, 8'h80, 0, 8'h9A, 8'hBC, 1, pk(0,0,0,0,0,0,1,0,8'h9A,8'hBC)));
    tbl.push_back(mk(4,     1, 8'h77, 8'h66, 0, 8'h9A, 8'hBC, 1, pk(0,0,0,0,0,0,1,0,8'h9A,8'hBC)));
    // Requester 0 start failure: done0 and err together START_WIN cycles after o_wr.
    tbl.push_back(mk(1,     1, 8'h77, 8'h66, 0, 8'h9A, 8'hBC, 0, pk(1,0,0,0,0,0,0,1,8'h77,8'h66)));
    tbl.push_back(mk(1,     0, 8'h77, 8'h66, 0, 8'h9A, 8'hBC, 0, pk(0,0,1,0,0,0,0,1,8'h77,8'h66)));
    tbl.push_back(mk(SW,    0, 8'h77, 8'h66, 0, 8'h9A, 8'hBC, 0, pk(0,0,0,1,0,1,0,1,8'h77,8'h66)));
    tbl.push_back(mk(GAP,   0, 8'h77, 8'h66, 0, 8'h9A, 8'hBC, 0, pk(0,0,0,0,0,0,0,0,8'h77,8'h66)));

    foreach (tbl[i]) begin
      req0 = tbl[i].r0; a0 = tbl[i].a0; d0 = tbl[i].d0;
      req1 = tbl[i].r1; a1 = tbl[i].a1; d1 = tbl[i].d1;
      mb   = tbl[i].mb;
      step(tbl[i].n);
      check($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
    end

    // Reset while RUN: everything clears, no done, next ack waits for busy to fall.
    req0 = 1'b1; a0 = 8'hAB; d0 = 8'hCD;
    step(1);
    check("rst_seq_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    step(1);
    mb = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    check("rst_outputs_zero", 32'(outs), 32'h0);
    rst = 1'b0;
    req1 = 1'b1; a1 = 8'hEF; d1 = 8'h10;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (done0 || done1 || ack1) seen++;
    end
    check("rst_no_done_no_ack", 32'(seen), 32'd0);
    mb = 1'b0;
    step(1);
    check("rst_ack1_after_busy", 32'({ack1, reg_addr, wdata}), 32'({1'b1, 8'hEF, 8'h10}));
    req1 = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      step(1);
      k++;
    end
    check("rst_seq_idle_bound", 32'(k < 40), 32'd1);

    // Both requesters held high back to back; grant order depends on the arbitration build.
    req0 = 1'b1; req1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (!(ack0 || ack1) && k < 40) begin
        step(1);
        k++;
      end
`ifdef SCCB_ARB_RR_EN
      exp_who = g[0];
`else
      exp_who = 1'b0;
`endif
      check($sformatf("b2b_ack_seen%0d", g), 32'(k < 40), 32'd1);
      check($sformatf("b2b_winner%0d", g), 32'({ack0, ack1}), 32'({~exp_who, exp_who}));
      step(1);
    end
    req0 = 1'b0; req1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
